// File: rtl/parking_spot_allocator.sv
// Occupancy bitmap and entry/exit gate controller for the smart parking system.
// Serves one exit or one entry gate cycle at a time and keeps a registered free-spot count.
module parking_spot_allocator #(
    parameter int NUM_SPOTS    = 8,
    parameter int GATE_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [2:0] exit_spot,
    input  logic       gate_pass,
    output logic       entry_ack,
    output logic       entry_reject,
    output logic       exit_ack,
    output logic       exit_reject,
    output logic       gate_open,
    output logic [7:0] park_location,
    output logic       loc_valid,
    output logic [7:0] parking_capacity,
    output logic [7:0] occupancy,
    output logic       full
);

    localparam logic [7:0] SPOT_MASK    = 8'((9'd1 << NUM_SPOTS) - 9'd1);
    localparam logic [7:0] CAP_RESET    = 8'(NUM_SPOTS);
    localparam logic [7:0] TIMEOUT_LAST = 8'(GATE_TIMEOUT - 1);
    localparam logic [3:0] NUM_SPOTS_W  = 4'(NUM_SPOTS);

    typedef enum logic [1:0] {
        IDLE,
        GATE_WAIT,
        COMMIT_IN
    } state_t;

    state_t     state;
    logic [7:0] timer;
    logic [2:0] alloc;
    logic [7:0] free_map;
    logic [2:0] free_idx;
    logic       entry_live;
    logic       exit_live;
    logic       exit_hit;

    // A requester still sees its ack/reject for one cycle before dropping req,
    // so a request arriving alongside its own pulse is treated as stale.
    always_comb begin
        free_map = ~occupancy & SPOT_MASK;
        free_idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (free_map[i]) begin
                free_idx = 3'(i);
            end
        end
        entry_live = entry_req && !(entry_ack || entry_reject);
        exit_live  = exit_req && !(exit_ack || exit_reject);
        exit_hit   = ({1'b0, exit_spot} < NUM_SPOTS_W) && occupancy[exit_spot];
    end

    assign full = (parking_capacity == 8'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            timer            <= '0;
            alloc            <= '0;
            occupancy        <= '0;
            parking_capacity <= CAP_RESET;
            entry_ack        <= 1'b0;
            entry_reject     <= 1'b0;
            exit_ack         <= 1'b0;
            exit_reject      <= 1'b0;
            gate_open        <= 1'b0;
            park_location    <= '0;
            loc_valid        <= 1'b0;
        end else begin
            entry_ack     <= 1'b0;
            entry_reject  <= 1'b0;
            exit_ack      <= 1'b0;
            exit_reject   <= 1'b0;
            park_location <= '0;
            loc_valid     <= 1'b0;
            case (state)
                IDLE: begin
                    // Exits take priority; they free a spot and never touch the gate.
                    if (exit_live) begin
                        if (exit_hit) begin
                            occupancy[exit_spot] <= 1'b0;
                            parking_capacity     <= parking_capacity + 8'd1;
                            park_location        <= 8'd1 << exit_spot;
                            loc_valid            <= 1'b1;
                            exit_ack             <= 1'b1;
                        end else begin
                            exit_reject <= 1'b1;
                        end
                    end else if (entry_live) begin
                        if (full) begin
                            entry_reject <= 1'b1;
                        end else begin
                            alloc     <= free_idx;
                            gate_open <= 1'b1;
                            timer     <= '0;
                            state     <= GATE_WAIT;
                        end
                    end
                end
                GATE_WAIT: begin
                    if (gate_pass) begin
                        state <= COMMIT_IN;
                    end else if (timer == TIMEOUT_LAST) begin
                        gate_open    <= 1'b0;
                        entry_reject <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                COMMIT_IN: begin
                    occupancy[alloc] <= 1'b1;
                    parking_capacity <= parking_capacity - 8'd1;
                    park_location    <= 8'd1 << alloc;
                    loc_valid        <= 1'b1;
                    entry_ack        <= 1'b1;
                    gate_open        <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_parking_spot_allocator.sv
// Self-checking bench for parking_spot_allocator: directed scenarios plus random
// entry/exit traffic checked against a spot-level occupancy model.
module tb_parking_spot_allocator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       entry_req;
    logic       exit_req;
    logic [2:0] exit_spot;
    logic       gate_pass;
    logic       entry_ack;
    logic       entry_reject;
    logic       exit_ack;
    logic       exit_reject;
    logic       gate_open;
    logic [7:0] park_location;
    logic       loc_valid;
    logic [7:0] parking_capacity;
    logic [7:0] occupancy;
    logic       full;

    int         checks   = 0;
    int         failures = 0;
    bit         inv_en   = 0;
    logic [7:0] model_occ;

    parking_spot_allocator #(.NUM_SPOTS(8), .GATE_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .entry_req(entry_req), .exit_req(exit_req),
        .exit_spot(exit_spot), .gate_pass(gate_pass), .entry_ack(entry_ack),
        .entry_reject(entry_reject), .exit_ack(exit_ack), .exit_reject(exit_reject),
        .gate_open(gate_open), .park_location(park_location), .loc_valid(loc_valid),
        .parking_capacity(parking_capacity), .occupancy(occupancy), .full(full)
    );

    always #5 clk = ~clk;

    // Invariants that must hold on every cycle once reset has been applied.
    always @(negedge clk) begin
        if (inv_en) begin
            checks++;
            if (parking_capacity !== 8'(8 - $countones(occupancy)) || full !== (parking_capacity == 8'd0)) begin
                failures++;
                $display("FAIL invariant_capacity cap=%0d occ=%02h full=%0b", parking_capacity, occupancy, full);
            end
            checks++;
            if (loc_valid ? !$onehot(park_location) : (park_location !== 8'h00)) begin
                failures++;
                $display("FAIL invariant_location loc_valid=%0b park_location=%02h", loc_valid, park_location);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lowest_free(input logic [7:0] occ);
        for (int i = 0; i < 8; i++) if (!occ[i]) return i;
        return -1;
    endfunction

    // Drives one entry; gate_pass is raised once gate_open has been seen pass_delay times.
    task automatic do_entry(input int pass_delay, output int open_cycles, output logic acked,
                            output logic rejected, output logic [7:0] loc);
        int cycles;
        bit pass_done;
        cycles = 0; pass_done = 0; open_cycles = 0; acked = 0; rejected = 0; loc = 0;
        entry_req = 1;
        while (!acked && !rejected && cycles < 64) begin
            tick();
            cycles++;
            gate_pass = 0;
            if (gate_open) open_cycles++;
            if (entry_ack) begin acked = 1; loc = loc_valid ? park_location : 8'h00; entry_req = 0; end
            if (entry_reject) begin rejected = 1; entry_req = 0; end
            if (!pass_done && gate_open && open_cycles == pass_delay) begin gate_pass = 1; pass_done = 1; end
        end
        entry_req = 0;
        gate_pass = 0;
    endtask

    task automatic do_exit(input int spot, output logic acked, output logic rejected, output logic [7:0] loc);
        int cycles;
        cycles = 0; acked = 0; rejected = 0; loc = 0;
        exit_req = 1;
        exit_spot = 3'(spot);
        while (!acked && !rejected && cycles < 64) begin
            tick();
            cycles++;
            if (exit_ack) begin acked = 1; loc = loc_valid ? park_location : 8'h00; exit_req = 0; end
            if (exit_reject) begin rejected = 1; exit_req = 0; end
        end
        exit_req = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; entry_req = 0; exit_req = 0; exit_spot = 0; gate_pass = 0;
        tick(); tick();
        checks++;
        if ({entry_ack, entry_reject, exit_ack, exit_reject, gate_open, loc_valid} !== 6'b0) begin
            failures++; $display("FAIL reset_pulses got=%06b want=000000",
                {entry_ack, entry_reject, exit_ack, exit_reject, gate_open, loc_valid});
        end
        checks++;
        if (parking_capacity !== 8'd8 || occupancy !== 8'h00 || park_location !== 8'h00 || full !== 1'b0) begin
            failures++; $display("FAIL reset_state cap=%0d occ=%02h loc=%02h full=%0b want cap=8 occ=00 loc=00 full=0",
                parking_capacity, occupancy, park_location, full);
        end
        rst_n = 1;
        model_occ = 8'h00;
        inv_en = 1;
        tick();
    endtask

    task automatic test_back_to_back();
        int open_c; logic ack, rej; logic [7:0] loc;
        for (int i = 0; i < 8; i++) begin
            do_entry(2, open_c, ack, rej, loc);
            checks++;
            if (ack !== 1'b1 || rej !== 1'b0 || loc !== 8'(1 << i) || open_c != 3) begin
                failures++; $display("FAIL b2b_entry%0d ack=%0b rej=%0b loc=%02h open=%0d want ack=1 rej=0 loc=%02h open=3",
                    i, ack, rej, loc, open_c, 8'(1 << i));
            end
            model_occ[i] = 1'b1;
        end
        checks++;
        if (parking_capacity !== 8'd0 || full !== 1'b1 || occupancy !== 8'hFF) begin
            failures++; $display("FAIL b2b_final cap=%0d full=%0b occ=%02h want cap=0 full=1 occ=ff",
                parking_capacity, full, occupancy);
        end
    endtask

    task automatic test_full_lot();
        tick();
        entry_req = 1;
        tick();
        checks++;
        if (entry_reject !== 1'b1 || gate_open !== 1'b0 || entry_ack !== 1'b0) begin
            failures++; $display("FAIL full_reject rej=%0b gate=%0b ack=%0b want rej=1 gate=0 ack=0",
                entry_reject, gate_open, entry_ack);
        end
        tick();
        checks++;
        if (entry_reject !== 1'b0 || gate_open !== 1'b0) begin
            failures++; $display("FAIL full_held_req rej=%0b gate=%0b want rej=0 gate=0", entry_reject, gate_open);
        end
        entry_req = 0;
        tick();
        checks++;
        if (occupancy !== 8'hFF) begin
            failures++; $display("FAIL full_occ got=%02h want=ff", occupancy);
        end
    endtask

    task automatic test_exit_refill();
        int open_c; logic ack, rej; logic [7:0] loc;
        do_exit(3, ack, rej, loc);
        checks++;
        if (ack !== 1'b1 || loc !== 8'h08 || occupancy !== 8'hF7 || parking_capacity !== 8'd1) begin
            failures++; $display("FAIL exit3 ack=%0b loc=%02h occ=%02h cap=%0d want ack=1 loc=08 occ=f7 cap=1",
                ack, loc, occupancy, parking_capacity);
        end
        do_entry(2, open_c, ack, rej, loc);
        checks++;
        if (ack !== 1'b1 || loc !== 8'h08 || occupancy !== 8'hFF) begin
            failures++; $display("FAIL refill3 ack=%0b loc=%02h occ=%02h want ack=1 loc=08 occ=ff", ack, loc, occupancy);
        end
    endtask

    task automatic test_timeout();
        int open_c; logic ack, rej; logic [7:0] loc;
        do_exit(6, ack, rej, loc);
        do_entry(100, open_c, ack, rej, loc);
        checks++;
        if (rej !== 1'b1 || ack !== 1'b0 || open_c != 15) begin
            failures++; $display("FAIL timeout rej=%0b ack=%0b open=%0d want rej=1 ack=0 open=15", rej, ack, open_c);
        end
        checks++;
        if (occupancy !== 8'hBF || parking_capacity !== 8'd1) begin
            failures++; $display("FAIL timeout_state occ=%02h cap=%0d want occ=bf cap=1", occupancy, parking_capacity);
        end
        do_entry(15, open_c, ack, rej, loc);
        checks++;
        if (ack !== 1'b1 || rej !== 1'b0 || loc !== 8'h40 || open_c != 16) begin
            failures++; $display("FAIL pass_at_timeout ack=%0b rej=%0b loc=%02h open=%0d want ack=1 rej=0 loc=40 open=16",
                ack, rej, loc, open_c);
        end
    endtask

    task automatic test_simultaneous();
        int open_c; logic ack, rej; logic [7:0] loc;
        tick();
        entry_req = 1; exit_req = 1; exit_spot = 3'd0;
        tick();
        checks++;
        if (exit_ack !== 1'b1 || park_location !== 8'h01 || gate_open !== 1'b0 || entry_ack !== 1'b0) begin
            failures++; $display("FAIL simul_exit_first exit_ack=%0b loc=%02h gate=%0b want exit_ack=1 loc=01 gate=0",
                exit_ack, park_location, gate_open);
        end
        tick();
        checks++;
        if (exit_ack !== 1'b0 || exit_reject !== 1'b0 || gate_open !== 1'b1) begin
            failures++; $display("FAIL simul_entry_next exit_ack=%0b exit_rej=%0b gate=%0b want 0 0 1",
                exit_ack, exit_reject, gate_open);
        end
        exit_req = 0;
        do_entry(2, open_c, ack, rej, loc);
        checks++;
        if (ack !== 1'b1 || loc !== 8'h01 || occupancy !== 8'hFF) begin
            failures++; $display("FAIL simul_entry ack=%0b loc=%02h occ=%02h want ack=1 loc=01 occ=ff", ack, loc, occupancy);
        end
        do_exit(5, ack, rej, loc);
        do_exit(5, ack, rej, loc);
        checks++;
        if (rej !== 1'b1 || ack !== 1'b0 || loc !== 8'h00 || occupancy !== 8'hDF) begin
            failures++; $display("FAIL exit_clear_spot rej=%0b ack=%0b loc=%02h occ=%02h want rej=1 ack=0 loc=00 occ=df",
                rej, ack, loc, occupancy);
        end
    endtask

    task automatic test_reset_in_gate();
        tick();
        entry_req = 1;
        tick(); tick();
        checks++;
        if (gate_open !== 1'b1) begin
            failures++; $display("FAIL gate_before_reset got=%0b want=1", gate_open);
        end
        rst_n = 0; entry_req = 0;
        tick();
        checks++;
        if (gate_open !== 1'b0 || parking_capacity !== 8'd8 || occupancy !== 8'h00 || entry_ack !== 1'b0 || loc_valid !== 1'b0) begin
            failures++; $display("FAIL reset_in_gate gate=%0b cap=%0d occ=%02h ack=%0b lv=%0b want 0 8 00 0 0",
                gate_open, parking_capacity, occupancy, entry_ack, loc_valid);
        end
        rst_n = 1;
        model_occ = 8'h00;
        tick(); tick(); tick();
        checks++;
        if (entry_ack !== 1'b0 || gate_open !== 1'b0 || occupancy !== 8'h00) begin
            failures++; $display("FAIL after_reset_idle ack=%0b gate=%0b occ=%02h want 0 0 00", entry_ack, gate_open, occupancy);
        end
    endtask

    // Random traffic: the model tracks which spots are taken and predicts each outcome.
    task automatic test_random();
        int open_c, d, spot, exp_spot, exp_open;
        logic ack, rej; logic [7:0] loc;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) != 2) begin
                d = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(1, 6));
                exp_spot = lowest_free(model_occ);
                exp_open = (exp_spot < 0) ? 0 : ((d <= 15) ? d + 1 : 15);
                do_entry(d, open_c, ack, rej, loc);
                checks++;
                if (exp_spot < 0 || d > 15) begin
                    if (ack !== 1'b0 || rej !== 1'b1 || open_c != exp_open) begin
                        failures++; $display("FAIL rand_entry_reject n=%0d ack=%0b rej=%0b open=%0d want ack=0 rej=1 open=%0d",
                            n, ack, rej, open_c, exp_open);
                    end
                end else begin
                    if (ack !== 1'b1 || loc !== 8'(1 << exp_spot) || open_c != exp_open) begin
                        failures++; $display("FAIL rand_entry n=%0d ack=%0b loc=%02h open=%0d want ack=1 loc=%02h open=%0d",
                            n, ack, loc, open_c, 8'(1 << exp_spot), exp_open);
                    end
                    model_occ[exp_spot] = 1'b1;
                end
            end else begin
                spot = int'($urandom_range(0, 7));
                do_exit(spot, ack, rej, loc);
                checks++;
                if (model_occ[spot]) begin
                    if (ack !== 1'b1 || loc !== 8'(1 << spot)) begin
                        failures++; $display("FAIL rand_exit n=%0d spot=%0d ack=%0b loc=%02h want ack=1 loc=%02h",
                            n, spot, ack, loc, 8'(1 << spot));
                    end
                    model_occ[spot] = 1'b0;
                end else if (rej !== 1'b1 || ack !== 1'b0) begin
                    failures++; $display("FAIL rand_exit_reject n=%0d spot=%0d ack=%0b rej=%0b want ack=0 rej=1",
                        n, spot, ack, rej);
                end
            end
            checks++;
            if (occupancy !== model_occ || parking_capacity !== 8'(8 - $countones(model_occ))) begin
                failures++; $display("FAIL rand_state n=%0d occ=%02h cap=%0d want occ=%02h cap=%0d",
                    n, occupancy, parking_capacity, model_occ, 8 - $countones(model_occ));
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_full_lot();
        test_exit_refill();
        test_timeout();
        test_simultaneous();
        test_reset_in_gate();
        test_random();
        inv_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
